// File: rtl/fwd_hazard_scoreboard.sv
// Operand forwarding, long-latency scoreboard and stall watchdog for the decode stage.
// Define FWD_STATS_EN to add the saturating fwd_cnt/stall_cnt/sbfull_cnt statistics outputs.
module fwd_hazard_scoreboard #(
    parameter int NUM_SRC    = 2,
    parameter int NUM_STAGES = 2,
    parameter int SB_ENTRIES = 4,
    parameter int LAT_W      = 4,
    parameter int STALL_MAX  = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NUM_SRC*5-1:0]    src_reg,
    input  logic [NUM_SRC*32-1:0]   src_rf,
    output logic [NUM_SRC*32-1:0]   src_out,
    output logic [NUM_SRC-1:0]      fwd_f,
    input  logic [NUM_STAGES-1:0]   stg_wen,
    input  logic [NUM_STAGES*5-1:0] stg_reg,
    input  logic [NUM_STAGES*32-1:0] stg_data,
    input  logic [NUM_STAGES-1:0]   stg_rdy,
    input  logic                    sb_alloc,
    input  logic [4:0]              sb_reg,
    input  logic [LAT_W-1:0]        sb_lat,
    output logic                    sb_full,
    input  logic                    flush,
    output logic                    stall,
    output logic                    fault,
    output logic [1:0]              dbg_state
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]             fwd_cnt,
    output logic [31:0]             stall_cnt,
    output logic [31:0]             sbfull_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam int WD_W = $clog2(STALL_MAX + 1);

    state_t                 state_q, state_d;
    logic [WD_W-1:0]        wd_cnt_q, wd_cnt_d;
    logic [WD_W-1:0]        wd_inc;

    logic [SB_ENTRIES-1:0]  sb_valid;
    logic [4:0]             sb_reg_q [SB_ENTRIES];
    logic [LAT_W-1:0]       sb_cnt   [SB_ENTRIES];

    logic [SB_ENTRIES-1:0]  dup_sel;
    logic [SB_ENTRIES-1:0]  free_sel;
    logic [SB_ENTRIES-1:0]  alloc_sel;
    logic                   do_alloc;
    logic [LAT_W-1:0]       lat_eff;

    logic [NUM_SRC-1:0]     hazard;
    logic                   any_hazard;

    // Result packing: {hazard, forwarded, operand}. The first matching stage
    // decides; an unready youngest match hides any older ready copy.
    function automatic logic [33:0] resolve(input logic [4:0] r, input logic [31:0] rf);
        logic        found;
        logic [33:0] res;
        found = 1'b0;
        res   = {2'b00, rf};
        if (r == 5'd0) begin
            res = '0;
        end else begin
            for (int g = 0; g < NUM_STAGES; g++) begin
                if (!found && stg_wen[g] && (stg_reg[g*5 +: 5] == r)) begin
                    found = 1'b1;
                    if (stg_rdy[g]) res = {2'b01, stg_data[g*32 +: 32]};
                    else            res[33] = 1'b1;
                end
            end
            for (int e = 0; e < SB_ENTRIES; e++) begin
                if (sb_valid[e] && (sb_reg_q[e] == r)) res[33] = 1'b1;
            end
        end
        return res;
    endfunction

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_port
        logic [33:0] res;
        assign res                = resolve(src_reg[s*5 +: 5], src_rf[s*32 +: 32]);
        assign src_out[s*32 +: 32] = res[31:0];
        assign fwd_f[s]           = res[32];
        assign hazard[s]          = res[33];
    end

    assign any_hazard = |hazard;
    assign stall      = any_hazard && (state_q != ST_FAULT);
    assign fault      = (state_q == ST_FAULT);
    assign dbg_state  = state_q;
    assign sb_full    = &sb_valid;

    // A re-allocated register reuses its own entry; otherwise take the lowest
    // slot that was free before this edge.
    always_comb begin
        dup_sel  = '0;
        free_sel = '0;
        for (int i = 0; i < SB_ENTRIES; i++) begin
            dup_sel[i] = sb_valid[i] && (sb_reg_q[i] == sb_reg);
        end
        for (int i = SB_ENTRIES - 1; i >= 0; i--) begin
            if (!sb_valid[i]) begin
                free_sel    = '0;
                free_sel[i] = 1'b1;
            end
        end
        alloc_sel = (|dup_sel) ? dup_sel : free_sel;
    end

    assign do_alloc = sb_alloc && !sb_full && !flush;
    assign lat_eff  = (sb_lat == '0) ? LAT_W'(1) : sb_lat;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sb_valid <= '0;
            for (int i = 0; i < SB_ENTRIES; i++) begin
                sb_reg_q[i] <= '0;
                sb_cnt[i]   <= '0;
            end
        end else if (flush) begin
            sb_valid <= '0;
        end else begin
            for (int i = 0; i < SB_ENTRIES; i++) begin
                if (do_alloc && alloc_sel[i]) begin
                    sb_valid[i] <= 1'b1;
                    sb_reg_q[i] <= sb_reg;
                    sb_cnt[i]   <= lat_eff;
                end else if (sb_valid[i]) begin
                    if (sb_cnt[i] == LAT_W'(1)) sb_valid[i] <= 1'b0;
                    else                        sb_cnt[i]   <= sb_cnt[i] - LAT_W'(1);
                end
            end
        end
    end

    assign wd_inc = wd_cnt_q + WD_W'(1);

    // Watchdog counts consecutive stalled cycles, including the first one seen in RUN.
    always_comb begin
        state_d  = state_q;
        wd_cnt_d = wd_cnt_q;
        case (state_q)
            ST_RUN, ST_STALL: begin
                if (flush) begin
                    state_d  = ST_RUN;
                    wd_cnt_d = '0;
                end else if (any_hazard) begin
                    wd_cnt_d = wd_inc;
                    state_d  = (wd_inc >= WD_W'(STALL_MAX)) ? ST_FAULT : ST_STALL;
                end else begin
                    state_d  = ST_RUN;
                    wd_cnt_d = '0;
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default: begin
                state_d  = ST_RUN;
                wd_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_RUN;
            wd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

`ifdef FWD_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fwd_cnt    <= '0;
            stall_cnt  <= '0;
            sbfull_cnt <= '0;
        end else begin
            if ((|fwd_f) && (fwd_cnt != '1))                 fwd_cnt    <= fwd_cnt + 32'd1;
            if (stall && (stall_cnt != '1))                  stall_cnt  <= stall_cnt + 32'd1;
            if (sb_alloc && sb_full && (sbfull_cnt != '1))   sbfull_cnt <= sbfull_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Self-checking bench for fwd_hazard_scoreboard: directed scenarios plus a
// randomized run against a per-register reference model.
module tb_fwd_hazard_scoreboard;

    localparam int NE   = 4;
    localparam int SMAX = 8;

    logic        CLK, RST;
    logic [9:0]  src_reg;
    logic [63:0] src_rf;
    logic [63:0] src_out;
    logic [1:0]  fwd_f;
    logic [1:0]  stg_wen, stg_rdy;
    logic [9:0]  stg_reg;
    logic [63:0] stg_data;
    logic        sb_alloc;
    logic [4:0]  sb_reg;
    logic [3:0]  sb_lat;
    logic        sb_full, flush, stall, fault;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    fwd_hazard_scoreboard #(
        .NUM_SRC(2), .NUM_STAGES(2), .SB_ENTRIES(NE), .LAT_W(4), .STALL_MAX(SMAX)
    ) dut (
        .CLK(CLK), .RST(RST), .src_reg(src_reg), .src_rf(src_rf), .src_out(src_out),
        .fwd_f(fwd_f), .stg_wen(stg_wen), .stg_reg(stg_reg), .stg_data(stg_data),
        .stg_rdy(stg_rdy), .sb_alloc(sb_alloc), .sb_reg(sb_reg), .sb_lat(sb_lat),
        .sb_full(sb_full), .flush(flush), .stall(stall), .fault(fault), .dbg_state(dbg_state)
    );

    // Clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference model: remaining blocked cycles per register, watchdog run length.
    int          m_rem [32];
    int          m_run;
    bit          m_fault;
    logic [31:0] e_out [2];
    bit          e_fwd [2];
    bit          e_haz [2];
    bit          e_stall, e_full;

    function automatic void m_reset();
        for (int r = 0; r < 32; r++) m_rem[r] = 0;
        m_run   = 0;
        m_fault = 0;
    endfunction

    function automatic void m_comb();
        int occ;
        occ = 0;
        for (int r = 0; r < 32; r++) if (m_rem[r] > 0) occ++;
        e_full = (occ == NE);
        for (int s = 0; s < 2; s++) begin
            logic [4:0] r;
            int hit;
            r        = src_reg[s*5 +: 5];
            e_out[s] = src_rf[s*32 +: 32];
            e_fwd[s] = 0;
            e_haz[s] = 0;
            hit      = -1;
            if (r == 0) begin
                e_out[s] = 0;
            end else begin
                for (int g = 0; g < 2; g++)
                    if (hit < 0 && stg_wen[g] && stg_reg[g*5 +: 5] == r) hit = g;
                if (hit >= 0) begin
                    if (stg_rdy[hit]) begin
                        e_out[s] = stg_data[hit*32 +: 32];
                        e_fwd[s] = 1;
                    end else e_haz[s] = 1;
                end
                if (m_rem[r] > 0) e_haz[s] = 1;
            end
        end
        e_stall = (e_haz[0] || e_haz[1]) && !m_fault;
    endfunction

    function automatic void m_edge();
        bit any, full_pre;
        m_comb();
        any      = e_haz[0] || e_haz[1];
        full_pre = e_full;
        if (flush) begin
            for (int r = 0; r < 32; r++) m_rem[r] = 0;
        end else begin
            for (int r = 0; r < 32; r++) if (m_rem[r] > 0) m_rem[r]--;
            if (sb_alloc && !full_pre) m_rem[sb_reg] = (sb_lat == 0) ? 1 : int'(sb_lat);
        end
        if (!m_fault) begin
            if (flush) m_run = 0;
            else if (any) begin
                m_run++;
                if (m_run >= SMAX) m_fault = 1;
            end else m_run = 0;
        end
    endfunction

    // Driver tasks
    task automatic idle();
        src_reg = '0; src_rf = '0; stg_wen = '0; stg_rdy = '0; stg_reg = '0;
        stg_data = '0; sb_alloc = 0; sb_reg = '0; sb_lat = '0; flush = 0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        idle();
        RST = 1;
        step();
        RST = 0;
        m_reset();
    endtask

    task automatic test_reset();
        idle();
        RST = 1;
        #2;
        checks++; if (src_out !== 64'd0) begin failures++; $display("FAIL reset_src_out got %h exp 0", src_out); end
        checks++; if (fwd_f !== 2'b00)   begin failures++; $display("FAIL reset_fwd_f got %b exp 00", fwd_f); end
        checks++; if (sb_full !== 1'b0)  begin failures++; $display("FAIL reset_sb_full got %b exp 0", sb_full); end
        checks++; if (stall !== 1'b0)    begin failures++; $display("FAIL reset_stall got %b exp 0", stall); end
        checks++; if (fault !== 1'b0)    begin failures++; $display("FAIL reset_fault got %b exp 0", fault); end
        step();
        RST = 0;
    endtask

    task automatic test_priority();
        do_reset();
        src_reg[4:0] = 5; src_rf = {32'h1111_2222, 32'h3333_4444};
        stg_wen = 2'b11; stg_reg = {5'd5, 5'd5}; stg_data = {32'hBBBB, 32'hAAAA}; stg_rdy = 2'b11;
        @(negedge CLK);
        checks++; if (src_out[31:0] !== 32'hAAAA) begin failures++; $display("FAIL prio_src_out got %h exp AAAA", src_out[31:0]); end
        checks++; if (fwd_f[0] !== 1'b1)          begin failures++; $display("FAIL prio_fwd_f got %b exp 1", fwd_f[0]); end
        checks++; if (stall !== 1'b0)             begin failures++; $display("FAIL prio_stall got %b exp 0", stall); end
        checks++; if (src_out[63:32] !== 32'd0)   begin failures++; $display("FAIL prio_r0 got %h exp 0", src_out[63:32]); end
        stg_wen = 2'b10;
        #1;
        checks++; if (src_out[31:0] !== 32'hBBBB) begin failures++; $display("FAIL older_stage got %h exp BBBB", src_out[31:0]); end
        stg_wen = 2'b00;
        #1;
        checks++; if (src_out[31:0] !== 32'h3333_4444) begin failures++; $display("FAIL rf_path got %h exp 33334444", src_out[31:0]); end
        checks++; if (fwd_f[0] !== 1'b0)               begin failures++; $display("FAIL rf_fwd_f got %b exp 0", fwd_f[0]); end
    endtask

    task automatic test_load_use();
        do_reset();
        src_reg[9:5] = 8;
        stg_wen = 2'b11; stg_reg = {5'd8, 5'd8}; stg_data = {32'h5555, 32'h0}; stg_rdy = 2'b10;
        @(negedge CLK);
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL loaduse_stall got %b exp 1", stall); end
        step();
        stg_rdy = 2'b11; stg_data[31:0] = 32'h1234;
        @(negedge CLK);
        checks++; if (src_out[63:32] !== 32'h1234) begin failures++; $display("FAIL loaduse_data got %h exp 1234", src_out[63:32]); end
        checks++; if (fwd_f[1] !== 1'b1)           begin failures++; $display("FAIL loaduse_fwd got %b exp 1", fwd_f[1]); end
        checks++; if (stall !== 1'b0)              begin failures++; $display("FAIL loaduse_release got %b exp 0", stall); end
    endtask

    task automatic test_scoreboard();
        do_reset();
        sb_alloc = 1; sb_reg = 9; sb_lat = 3; src_reg[4:0] = 9;
        @(negedge CLK);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL sb_pre_alloc got %b exp 0", stall); end
        step();
        sb_alloc = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge CLK);
            checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sb_block_t%0d got %b exp 1", k, stall); end
            step();
        end
        @(negedge CLK);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL sb_expire got %b exp 0", stall); end
        step();
        sb_alloc = 1; sb_reg = 0; sb_lat = 5; src_reg = '0;
        step();
        sb_alloc = 0;
        @(negedge CLK);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL sb_r0 got %b exp 0", stall); end
        step();
        sb_alloc = 1; sb_reg = 7; sb_lat = 0; src_reg[4:0] = 7;
        step();
        sb_alloc = 0;
        @(negedge CLK);
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sb_lat0_block got %b exp 1", stall); end
        step();
        @(negedge CLK);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL sb_lat0_expire got %b exp 0", stall); end
    endtask

    task automatic test_full_overflow();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            sb_alloc = 1; sb_reg = 5'(i); sb_lat = 15;
            step();
        end
        sb_alloc = 0;
        @(negedge CLK);
        checks++; if (sb_full !== 1'b1) begin failures++; $display("FAIL full_set got %b exp 1", sb_full); end
        sb_alloc = 1; sb_reg = 6;
        step();
        sb_alloc = 0; src_reg[4:0] = 6;
        @(negedge CLK);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL full_drop got %b exp 0", stall); end
        src_reg[4:0] = 2;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL full_held got %b exp 1", stall); end
        flush = 1;
        step();
        flush = 0;
        @(negedge CLK);
        checks++; if (sb_full !== 1'b0) begin failures++; $display("FAIL flush_full got %b exp 0", sb_full); end
        checks++; if (stall !== 1'b0)   begin failures++; $display("FAIL flush_stall got %b exp 0", stall); end
    endtask

    task automatic test_watchdog();
        do_reset();
        sb_alloc = 1; sb_reg = 3; sb_lat = 15; src_reg[4:0] = 3;
        step();
        sb_alloc = 0;
        for (int k = 1; k <= SMAX; k++) begin
            @(negedge CLK);
            checks++; if (stall !== 1'b1 || fault !== 1'b0) begin failures++; $display("FAIL wd_cycle%0d got stall=%b fault=%b exp 1/0", k, stall, fault); end
            step();
        end
        @(negedge CLK);
        checks++; if (fault !== 1'b1) begin failures++; $display("FAIL wd_fault got %b exp 1", fault); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL wd_stall_drop got %b exp 0", stall); end
        flush = 1;
        step();
        flush = 0;
        @(negedge CLK);
        checks++; if (fault !== 1'b1) begin failures++; $display("FAIL wd_flush_sticky got %b exp 1", fault); end
        RST = 1;
        #1;
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL wd_rst_clear got %b exp 0", fault); end
        step();
        RST = 0;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            sb_alloc = 1; sb_reg = 5'(i); sb_lat = 15;
            step();
        end
        sb_alloc = 0; src_reg[4:0] = 1;
        @(negedge CLK);
        checks++; if (stall !== 1'b1 || sb_full !== 1'b1) begin failures++; $display("FAIL ar_setup got stall=%b full=%b exp 1/1", stall, sb_full); end
        #2;
        RST = 1;
        #1;
        checks++; if (stall !== 1'b0)   begin failures++; $display("FAIL ar_stall got %b exp 0", stall); end
        checks++; if (sb_full !== 1'b0) begin failures++; $display("FAIL ar_full got %b exp 0", sb_full); end
        checks++; if (fault !== 1'b0)   begin failures++; $display("FAIL ar_fault got %b exp 0", fault); end
        step();
        RST = 0;
        src_reg = {5'd2, 5'd1};
        @(negedge CLK);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL ar_entries_gone got %b exp 0", stall); end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            src_reg  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            src_rf   = {$urandom, $urandom};
            stg_wen  = 2'($urandom_range(0, 3));
            stg_reg  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            stg_data = {$urandom, $urandom};
            stg_rdy  = {1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) != 0)};
            sb_alloc = ($urandom_range(0, 4) == 0);
            sb_reg   = 5'($urandom_range(0, 7));
            sb_lat   = 4'($urandom_range(0, 6));
            flush    = ($urandom_range(0, 30) == 0);
            @(negedge CLK);
            m_comb();
            checks++; if (stall !== e_stall)   begin failures++; $display("FAIL rnd_stall c%0d got %b exp %b", cyc, stall, e_stall); end
            checks++; if (sb_full !== e_full)  begin failures++; $display("FAIL rnd_full c%0d got %b exp %b", cyc, sb_full, e_full); end
            checks++; if (fault !== m_fault)   begin failures++; $display("FAIL rnd_fault c%0d got %b exp %b", cyc, fault, m_fault); end
            for (int s = 0; s < 2; s++) begin
                if (!e_haz[s]) begin
                    checks++;
                    if (src_out[s*32 +: 32] !== e_out[s] || fwd_f[s] !== e_fwd[s]) begin
                        failures++;
                        $display("FAIL rnd_port%0d c%0d got %h/%b exp %h/%b", s, cyc, src_out[s*32 +: 32], fwd_f[s], e_out[s], e_fwd[s]);
                    end
                end
            end
            if (cyc % 64 == 63) begin
                RST = 1;
                m_reset();
                step();
                RST = 0;
            end else begin
                m_edge();
                step();
            end
        end
    endtask

    initial begin
        RST = 0;
        idle();
        test_reset();
        test_priority();
        test_load_use();
        test_scoreboard();
        test_full_overflow();
        test_watchdog();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_scoreboard.md
Name: fwd_hazard_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the pipelined and multicore CPU datapath.
- Resolves operands for NUM_SRC decode-stage source ports against NUM_STAGES producer stages, ordered youngest-first.
- Tracks long-latency writers (multiply/divide, cache-miss loads) in a counting scoreboard.
- Drives the pipeline stall, with a stall watchdog state machine.

Parameters:
NUM_SRC, 2, number of source operand ports
NUM_STAGES, 2, producer stages searched; index 0 = youngest (EX/MEM), highest = oldest (MEM/WB)
SB_ENTRIES, 4, scoreboard entries for long-latency writers
LAT_W, 4, width of latency countdown
STALL_MAX, 64, consecutive stall cycles before fault

Ports:
CLK  in  1  clock
RST  in  1  asynchronous reset, active-high
src_reg  in  NUM_SRC*5  source register numbers (regbits_t per port)
src_rf  in  NUM_SRC*32  register-file read data per port
src_out  out  NUM_SRC*32  resolved operand per port
fwd_f  out  NUM_SRC  1 = port took a forwarded value
stg_wen  in  NUM_STAGES  stage will write a register
stg_reg  in  NUM_STAGES*5  stage destination register
stg_data  in  NUM_STAGES*32  stage result
stg_rdy  in  NUM_STAGES  stage result valid now (0 for a load still in MEM)
sb_alloc  in  1  allocate a scoreboard entry
sb_reg  in  5  destination for allocation
sb_lat  in  LAT_W  cycles until result is visible to forwarding stages
sb_full  out  1  no free entry
flush  in  1  clears scoreboard, returns FSM to RUN
stall  out  1  hold fetch/decode
fault  out  1  sticky watchdog fault

Behaviour:
- Reset values: src_out=0, fwd_f=0, sb_full=0, stall=0, fault=0.
- Reset clears all scoreboard entries and forces the FSM to RUN. Reset is asynchronous and takes effect mid-operation.
- Operand resolution (combinational, per port s):
  - If src_reg[s]==0: src_out=0, fwd_f=0; never hazards.
  - Otherwise scan stages 0..NUM_STAGES-1 and take the first stage with stg_wen && stg_reg==src_reg[s].
    - If that stage has stg_rdy=1: src_out=stg_data, fwd_f=1.
    - If stg_rdy=0: raise a hazard for port s. Older stages are NOT consulted.
  - No match: src_out=src_rf, fwd_f=0.
- Scoreboard hazard: any valid entry with reg==src_reg[s] (nonzero) raises a hazard for port s regardless of stage matches.
- stall = (OR of hazards) && state!=FAULT. stall is combinational.
- Scoreboard entries: valid, reg[4:0], cnt[LAT_W-1:0].
  - Allocation on sb_alloc && !sb_full && !flush: lowest-index free entry is loaded with cnt=sb_lat.
    - sb_lat==0 is treated as 1.
    - If the new reg matches an existing valid entry, that entry is overwritten instead (cnt reloaded); no duplicate entries.
  - Each cycle every valid entry with cnt>1 decrements; an entry with cnt==1 clears valid on that edge. An entry allocated at edge t with lat L blocks readers for cycles t+1 .. t+L.
  - sb_alloc while sb_full is dropped silently; the issuing stage must check sb_full first.
  - sb_full = all entries valid (registered view, updated every edge).
  - Allocation and expiry on the same edge: expiry frees its slot first, but the new entry is placed only in a slot free before the edge.
- FSM states RUN, STALL, FAULT.
  - RUN -> STALL when a hazard is present. STALL -> RUN when the hazard clears.
  - A stall counter increments in STALL and resets to 0 on entry to RUN.
  - Counter reaching STALL_MAX -> FAULT. fault=1 and stall=0 in FAULT, letting the pipeline drain for debug.
  - FAULT is exited only by RST. flush in FAULT has no effect on the FSM.
- flush: clears all scoreboard entries on the edge. State RUN/STALL -> RUN. Stall counter -> 0. Has priority over same-cycle sb_alloc.

Optional Feature:
- FWD_STATS_EN defined adds three outputs: fwd_cnt[31:0], stall_cnt[31:0], sbfull_cnt[31:0].
  - fwd_cnt: cycles with any fwd_f=1.
  - stall_cnt: cycles with stall=1.
  - sbfull_cnt: dropped allocations.
  - All counters saturate at 0xFFFFFFFF and are cleared by RST, not by flush.
- Undefined: the outputs and counters are absent and the core behaviour is identical.

Test Plan:
- Priority: src_reg[0]=5, stage0 wen/reg5/data 0xAAAA/rdy=1, stage1 wen/reg5/data 0xBBBB -> src_out[0]=0xAAAA, fwd_f[0]=1, stall=0.
- Load-use: stage0 reg 8 rdy=0, src_reg[1]=8, stage1 reg8 rdy=1 -> stall=1 (older stage ignored); next cycle stage0 rdy=1 data 0x1234 -> src_out[1]=0x1234, stall=0.
- Scoreboard: alloc reg 9 lat 3 at edge t, src_reg[0]=9 -> stall=1 during cycles t+1..t+3, 0 at t+4. A read of $0 never stalls.
- Full/overflow: 4 allocations regs 1-4 lat 15 -> sb_full=1; 5th alloc reg 6 dropped, reading reg 6 does not stall; flush -> sb_full=0, no stalls.
- Watchdog: STALL_MAX=8, hold a scoreboard hazard with lat 15 -> fault=1 and stall=0 after 8 stall cycles; flush leaves fault=1; RST clears it.
- Async reset mid-stall: assert RST between edges with entries valid -> stall, sb_full and fault drop immediately, all entries invalid after release.
